// File: rtl/exp_batch_controller.sv
// rtl/exp_batch_controller.sv - batch sequencer feeding operands to an exponential accelerator
// Optional build macro: EXP_CTRL_TIMEOUT_EN (bounded WAIT with sticky timeout_err).
module exp_batch_controller #(
  parameter int DEPTH = 16,
  parameter int XW    = 16,
  parameter int RW    = 18
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [XW-1:0]            wr_data,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     read_switch,
  input  logic                     acc_done,
  input  logic [RW-1:0]            acc_result,
  output logic                     acc_start,
  output logic [XW-1:0]            acc_x,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   load_count,
  output logic                     overflow,
  output logic [$clog2(DEPTH)-1:0] rd_index,
  output logic [RW-1:0]            rd_data,
  output logic                     timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_STORE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   load_count_q, load_count_d;
  logic [AW-1:0]   index_q, index_d;
  logic [AW-1:0]   rd_index_q, rd_index_d;
  logic            overflow_q, overflow_d;
  logic [XW-1:0]   acc_x_q, acc_x_d;
  logic            rs_q;

  logic [XW-1:0]   operand_q [DEPTH];
  logic [RW-1:0]   result_q  [DEPTH];

  logic            op_we;
  logic            res_we;
  logic [RW-1:0]   res_wdata;
  logic            wr_ok;
  logic            rs_rise;
  logic            full;
  logic [AW-1:0]   index_nxt;

`ifdef EXP_CTRL_TIMEOUT_EN
  logic [7:0]      wait_cnt_q, wait_cnt_d;
  logic            timeout_q, timeout_d;
`endif

  assign full      = (load_count_q == CW'(DEPTH));
  assign rs_rise   = read_switch & ~rs_q;
  assign index_nxt = index_q + AW'(1);

  // Next-state, datapath updates and array write strobes
  always_comb begin
    state_d      = state_q;
    load_count_d = load_count_q;
    index_d      = index_q;
    rd_index_d   = rd_index_q;
    overflow_d   = overflow_q;
    acc_x_d      = acc_x_q;
    op_we        = 1'b0;
    res_we       = 1'b0;
    res_wdata    = acc_result;
    wr_ok        = 1'b0;
`ifdef EXP_CTRL_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = timeout_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (clear) begin
          // Clear beats start and any write presented in the same cycle.
          state_d      = S_IDLE;
          load_count_d = '0;
`ifdef EXP_CTRL_TIMEOUT_EN
          timeout_d    = 1'b0;
`endif
        end else begin
          if (wr_en) begin
            if (!full) begin
              op_we        = 1'b1;
              wr_ok        = 1'b1;
              load_count_d = load_count_q + CW'(1);
            end else begin
              overflow_d = 1'b1;
            end
          end
          // A write landing with start joins the batch; entry 0 may be that write.
          if (start && (load_count_q != '0 || wr_ok)) begin
            state_d = S_ISSUE;
            index_d = '0;
            acc_x_d = (load_count_q == '0) ? wr_data : operand_q[0];
`ifdef EXP_CTRL_TIMEOUT_EN
            timeout_d = 1'b0;
`endif
          end else if (state_q == S_DONE && rs_rise) begin
            rd_index_d = ({1'b0, rd_index_q} + CW'(1) >= load_count_q) ? '0 : rd_index_q + AW'(1);
          end
        end
      end

      S_ISSUE: begin
        if (wr_en) overflow_d = 1'b1;
        state_d = S_WAIT;
`ifdef EXP_CTRL_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end

      S_WAIT: begin
        if (wr_en) overflow_d = 1'b1;
        if (acc_done) begin
          res_we  = 1'b1;
          state_d = S_STORE;
        end
`ifdef EXP_CTRL_TIMEOUT_EN
        // The 255th consecutive WAIT cycle without completion gives up on this entry.
        else if (wait_cnt_q == 8'd254) begin
          res_we    = 1'b1;
          res_wdata = '1;
          timeout_d = 1'b1;
          state_d   = S_STORE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
`endif
      end

      S_STORE: begin
        if (wr_en) overflow_d = 1'b1;
        if ({1'b0, index_q} == load_count_q - CW'(1)) begin
          state_d    = S_DONE;
          rd_index_d = '0;
        end else begin
          state_d = S_ISSUE;
          index_d = index_nxt;
          acc_x_d = operand_q[index_nxt];
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      load_count_q <= '0;
      index_q      <= '0;
      rd_index_q   <= '0;
      overflow_q   <= 1'b0;
      acc_x_q      <= '0;
      rs_q         <= 1'b0;
`ifdef EXP_CTRL_TIMEOUT_EN
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      load_count_q <= load_count_d;
      index_q      <= index_d;
      rd_index_q   <= rd_index_d;
      overflow_q   <= overflow_d;
      acc_x_q      <= acc_x_d;
      rs_q         <= read_switch;
`ifdef EXP_CTRL_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  // Operand and result storage; contents are not reset
  always_ff @(posedge clk) begin
    if (reset && op_we)  operand_q[load_count_q[AW-1:0]] <= wr_data;
    if (reset && res_we) result_q[index_q]               <= res_wdata;
  end

  assign acc_start  = (state_q == S_ISSUE);
  assign acc_x      = acc_x_q;
  assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_STORE);
  assign done       = (state_q == S_DONE);
  assign load_count = load_count_q;
  assign overflow   = overflow_q;
  assign rd_index   = rd_index_q;
  assign rd_data    = result_q[rd_index_q];

`ifdef EXP_CTRL_TIMEOUT_EN
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
